// File: rtl/seg_scan_if.sv
// seg_scan_if
//   Bundle between the front-panel interface FSM (master) and the
//   7-segment scan driver (slave).
//   data_in      master->slave  packed digit image, {DP,g..a} per digit,
//                               digit 0 (leftmost) in the top byte
//   mode         master->slave  0 constant, 1 flash, 2 blank, 3-7 constant
//   seg_sel      slave->master  one-hot digit select
//   seg_out      slave->master  segment drive for the selected digit
//   flash_cnt    slave->master  completed flash cycles, saturating at 7
//   frame_start  slave->master  1-cycle pulse when the digit index wraps
interface seg_scan_if #(
    parameter int DIGITS = 5
);
    logic [8*DIGITS-1:0] data_in;
    logic [2:0]          mode;
    logic [DIGITS-1:0]   seg_sel;
    logic [7:0]          seg_out;
    logic [2:0]          flash_cnt;
    logic                frame_start;

    modport master (
        output data_in, mode,
        input  seg_sel, seg_out, flash_cnt, frame_start
    );

    modport slave (
        input  data_in, mode,
        output seg_sel, seg_out, flash_cnt, frame_start
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed 7-segment scan driver. Scans DIGITS digits onto a shared
//   segment bus, one digit per SCAN_DIV-cycle slot, with the first BLANK_CYC
//   cycles of each slot blanked to suppress ghosting. The image is latched
//   into a shadow register only at frame boundaries so it never tears.
//   Supports constant, flash and blank display modes and reports completed
//   flash cycles back to the interface FSM.
// Ports
//   clk     in   system clock
//   reset   in   synchronous reset, active-low
//   ctrl    slave modport of seg_scan_if (data_in/mode in;
//           seg_sel/seg_out/flash_cnt/frame_start out)
//
// Flash phase FSM
//   state  | meaning
//   PH_ON  | digits displayed normally while in flash mode
//   PH_OFF | display blanked while in flash mode
module seg_scan_driver #(
    parameter int DIGITS      = 5,
    parameter int SCAN_DIV    = 20000,
    parameter int BLANK_CYC   = 200,
    parameter int FLASH_TICKS = 100,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    seg_scan_if.slave  ctrl
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    localparam logic [PW-1:0]     PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]     BLANK_END = PW'(BLANK_CYC);
    localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [FW-1:0]     FLASH_MAX = FW'(FLASH_TICKS - 1);
    localparam logic [2:0]        MODE_FLASH = 3'd1;
    localparam logic [2:0]        MODE_BLANK = 3'd2;
    localparam logic [DIGITS-1:0] SEL_IDLE  = SEL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [8*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]   r_seg_sel;
    logic [7:0]          r_seg_out;
    logic                r_frame_start;

    phase_t              r_phase;
    phase_t              w_phase_nxt;
    logic [FW-1:0]       r_slot_cnt;
    logic [FW-1:0]       w_slot_cnt_nxt;
    logic [2:0]          r_flash_cnt;
    logic [2:0]          w_flash_cnt_nxt;
    logic                r_prev_flash;

    logic                w_slot_tick;
    logic                w_frame_end;
    logic                w_is_flash;
    logic                w_entry;
    logic                w_blank;
    logic [IW-1:0]       w_sel_pos;
    logic [DIGITS-1:0]   w_sel_act;
    logic [7:0]          w_digit;

    assign w_slot_tick = (r_presc == PRESC_MAX);
    assign w_frame_end = w_slot_tick && (r_idx == IDX_MAX);
    assign w_is_flash  = (ctrl.mode == MODE_FLASH);
    assign w_entry     = w_is_flash && !r_prev_flash;

    // Digit 0 sits in the top byte and drives the MSB select line.
    assign w_sel_pos = IDX_MAX - r_idx;
    assign w_digit   = r_shadow[{w_sel_pos, 3'b000} +: 8];

    always_comb begin
        w_sel_act            = '0;
        w_sel_act[w_sel_pos] = 1'b1;
    end

    // On the entry cycle the phase is forced ON, so a stale OFF phase left
    // over from an earlier flash session must not blank this cycle.
    assign w_blank = (r_presc < BLANK_END)
                  || (ctrl.mode == MODE_BLANK)
                  || (w_is_flash && !w_entry && (r_phase == PH_OFF));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_seg_sel     <= SEL_IDLE;
            r_seg_out     <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_slot_tick ? '0 : r_presc + PW'(1);
            if (w_slot_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            end
            if (w_frame_end) begin
                r_shadow <= ctrl.data_in;
            end
            r_frame_start <= w_frame_end;
            r_seg_sel     <= w_blank ? SEL_IDLE : (SEL_ACT_LOW ? ~w_sel_act : w_sel_act);
            r_seg_out     <= w_blank ? 8'h00 : w_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase      <= PH_ON;
            r_slot_cnt   <= '0;
            r_flash_cnt  <= 3'd0;
            r_prev_flash <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_slot_cnt   <= w_slot_cnt_nxt;
            r_flash_cnt  <= w_flash_cnt_nxt;
            r_prev_flash <= w_is_flash;
        end
    end

    // Entry outranks a coincident slot tick; outside flash mode the
    // counters and phase simply hold.
    always_comb begin
        w_phase_nxt     = r_phase;
        w_slot_cnt_nxt  = r_slot_cnt;
        w_flash_cnt_nxt = r_flash_cnt;
        if (w_entry) begin
            w_phase_nxt     = PH_ON;
            w_slot_cnt_nxt  = '0;
            w_flash_cnt_nxt = 3'd0;
        end else if (w_is_flash && w_slot_tick) begin
            if (r_slot_cnt == FLASH_MAX) begin
                w_slot_cnt_nxt = '0;
                case (r_phase)
                    PH_ON: begin
                        w_phase_nxt = PH_OFF;
                    end
                    PH_OFF: begin
                        w_phase_nxt = PH_ON;
                        if (r_flash_cnt != 3'd7) begin
                            w_flash_cnt_nxt = r_flash_cnt + 3'd1;
                        end
                    end
                    default: begin
                        w_phase_nxt = PH_ON;
                    end
                endcase
            end else begin
                w_slot_cnt_nxt = r_slot_cnt + FW'(1);
            end
        end
    end

    assign ctrl.seg_sel     = r_seg_sel;
    assign ctrl.seg_out     = r_seg_out;
    assign ctrl.flash_cnt   = r_flash_cnt;
    assign ctrl.frame_start = r_frame_start;

endmodule
